// File: rtl/vga_stream_checker.sv
// In-view VGA pixel checker: compares the DUT pixel stream against a valid/ready expected-pixel
// stream (direct, 2-tap horizontal average or column replicate), counting and recording errors.
module vga_stream_checker #(
  parameter int CHANNELS    = 3,
  parameter int PIX_W       = 8,
  parameter int COORD_W     = 10,
  parameter int VIEW_LEFT   = 160,
  parameter int VIEW_RIGHT  = 480,
  parameter int VIEW_TOP    = 120,
  parameter int VIEW_BOTTOM = 360,
  parameter int ERR_W       = 16
) (
  input  logic                        Clock_50,
  input  logic                        Reset,
  input  logic                        Enable,
  input  logic [1:0]                  Mode,
  input  logic                        Frame_start,
  input  logic                        Pix_valid,
  input  logic [COORD_W-1:0]          Pix_X,
  input  logic [COORD_W-1:0]          Pix_Y,
  input  logic [CHANNELS*PIX_W-1:0]   Pix_data,
  input  logic                        Ref_valid,
  input  logic [CHANNELS*PIX_W-1:0]   Ref_data,
  output logic                        Ref_ready,
  output logic [ERR_W-1:0]            Mismatch_count,
  output logic                        First_err,
  output logic [COORD_W-1:0]          First_err_X,
  output logic [COORD_W-1:0]          First_err_Y,
  output logic [1:0]                  First_err_chan,
  output logic [PIX_W-1:0]            First_err_exp,
  output logic [PIX_W-1:0]            First_err_got,
  output logic                        Underflow,
  output logic                        Aborted,
  output logic                        Frame_done,
  output logic [1:0]                  State_dbg
);

  localparam int DW = CHANNELS * PIX_W;
  localparam logic [COORD_W-1:0] L_LEFT   = COORD_W'(VIEW_LEFT);
  localparam logic [COORD_W-1:0] L_RIGHT  = COORD_W'(VIEW_RIGHT);
  localparam logic [COORD_W-1:0] L_TOP    = COORD_W'(VIEW_TOP);
  localparam logic [COORD_W-1:0] L_BOTTOM = COORD_W'(VIEW_BOTTOM);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_CHECK = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            r_state, w_next;
  logic              r_buf_valid;
  logic [DW-1:0]     r_buf_data;
  logic [DW-1:0]     r_prev;
  logic [ERR_W-1:0]  r_count;
  logic              r_first_err;
  logic [COORD_W-1:0] r_first_x, r_first_y;
  logic [1:0]        r_first_chan;
  logic [PIX_W-1:0]  r_first_exp, r_first_got;
  logic              r_underflow, r_aborted;

  logic w_in_view, w_active, w_odd, w_use_prev, w_avg_mode;
  logic w_need, w_consume, w_underflow, w_compare, w_load, w_last;
  logic w_enter_check, w_abort;
  logic [CHANNELS-1:0] w_mis;
  logic [1:0]          w_first_chan;
  logic [PIX_W-1:0]    w_first_exp, w_first_got;
  logic [PIX_W-1:0]    w_ref_c, w_exp_c, w_got_c;
  logic [PIX_W:0]      w_avg;
  logic [ERR_W:0]      w_sum;
  logic [ERR_W-1:0]    w_count_next;

  assign w_in_view = (Pix_X >= L_LEFT) && (Pix_X < L_RIGHT) &&
                     (Pix_Y >= L_TOP) && (Pix_Y < L_BOTTOM);
  // A Frame_start during CHECK aborts the frame, so that cycle's pixel is not checked.
  assign w_active    = Enable && (r_state == S_CHECK) && !Frame_start && Pix_valid && w_in_view;
  assign w_odd       = Pix_X[0] ^ L_LEFT[0];
  assign w_use_prev  = (Mode == 2'd2) && w_odd;
  assign w_avg_mode  = (Mode == 2'd1) && (Pix_X != L_LEFT);
  assign w_need      = w_active && !w_use_prev;
  assign w_consume   = w_need && r_buf_valid;
  assign w_underflow = w_need && !r_buf_valid;
  assign w_compare   = w_consume || (w_active && w_use_prev);
  assign w_last      = w_active && (Pix_X == L_RIGHT - 1'b1) && (Pix_Y == L_BOTTOM - 1'b1);
  assign w_enter_check = Enable && Frame_start && ((r_state == S_WAIT) || (r_state == S_DONE));
  assign w_abort       = Enable && Frame_start && (r_state == S_CHECK);

  // Ref handshake: a word transfers on a cycle where Ref_valid and Ref_ready are both high.
  // Ready means the buffer is empty or is being consumed now, so consume+load in one cycle works.
  assign Ref_ready = ((r_state == S_WAIT) || (r_state == S_CHECK)) && (!r_buf_valid || w_consume);
  assign w_load    = Ref_valid && Ref_ready;

  always_comb begin
    w_next = r_state;
    if (!Enable) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  w_next = S_WAIT;
        S_WAIT:  if (Frame_start) w_next = S_CHECK;
        S_CHECK: if (Frame_start || w_last) w_next = S_DONE;
        S_DONE:  if (Frame_start) w_next = S_CHECK;
        default: w_next = S_IDLE;
      endcase
    end
  end

  // Walk channels high to low so the recorded channel ends up as the lowest mismatching one.
  always_comb begin
    w_mis        = '0;
    w_first_chan = '0;
    w_first_exp  = '0;
    w_first_got  = '0;
    w_ref_c      = '0;
    w_exp_c      = '0;
    w_got_c      = '0;
    w_avg        = '0;
    for (int c = CHANNELS - 1; c >= 0; c--) begin
      w_ref_c = w_use_prev ? r_prev[c*PIX_W +: PIX_W] : r_buf_data[c*PIX_W +: PIX_W];
      w_avg   = {1'b0, r_prev[c*PIX_W +: PIX_W]} + {1'b0, w_ref_c};
      w_exp_c = w_avg_mode ? w_avg[PIX_W:1] : w_ref_c;
      w_got_c = Pix_data[c*PIX_W +: PIX_W];
      if (w_exp_c != w_got_c) begin
        w_mis[c]     = 1'b1;
        w_first_chan = 2'(c);
        w_first_exp  = w_exp_c;
        w_first_got  = w_got_c;
      end
    end
  end

  always_comb begin
    w_sum = {1'b0, r_count};
    for (int c = 0; c < CHANNELS; c++) begin
      if (w_mis[c]) w_sum = w_sum + (ERR_W+1)'(1);
    end
    w_count_next = w_sum[ERR_W] ? '1 : w_sum[ERR_W-1:0];
  end

  always_ff @(posedge Clock_50 or posedge Reset) begin
    if (Reset) begin
      r_state      <= S_IDLE;
      r_buf_valid  <= 1'b0;
      r_buf_data   <= '0;
      r_prev       <= '0;
      r_count      <= '0;
      r_first_err  <= 1'b0;
      r_first_x    <= '0;
      r_first_y    <= '0;
      r_first_chan <= '0;
      r_first_exp  <= '0;
      r_first_got  <= '0;
      r_underflow  <= 1'b0;
      r_aborted    <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_load) begin
        r_buf_valid <= 1'b1;
        r_buf_data  <= Ref_data;
      end else if (w_consume) begin
        r_buf_valid <= 1'b0;
      end
      if (w_consume) r_prev <= r_buf_data;
      if (w_enter_check) begin
        r_count      <= '0;
        r_first_err  <= 1'b0;
        r_first_x    <= '0;
        r_first_y    <= '0;
        r_first_chan <= '0;
        r_first_exp  <= '0;
        r_first_got  <= '0;
        r_underflow  <= 1'b0;
        r_aborted    <= 1'b0;
      end else begin
        if (w_abort) r_aborted <= 1'b1;
        if (w_underflow) r_underflow <= 1'b1;
        if (w_compare && (w_mis != '0)) begin
          r_count <= w_count_next;
          if (!r_first_err) begin
            r_first_err  <= 1'b1;
            r_first_x    <= Pix_X;
            r_first_y    <= Pix_Y;
            r_first_chan <= w_first_chan;
            r_first_exp  <= w_first_exp;
            r_first_got  <= w_first_got;
          end
        end
      end
    end
  end

  assign Mismatch_count = r_count;
  assign First_err      = r_first_err;
  assign First_err_X    = r_first_x;
  assign First_err_Y    = r_first_y;
  assign First_err_chan = r_first_chan;
  assign First_err_exp  = r_first_exp;
  assign First_err_got  = r_first_got;
  assign Underflow      = r_underflow;
  assign Aborted        = r_aborted;
  assign Frame_done     = (r_state == S_DONE);
  assign State_dbg      = r_state;

endmodule

// File: tb/tb_vga_stream_checker.sv
// Directed bench for vga_stream_checker: small 4x2 view at (1..4, 1..2), 4-bit error counter.
module tb_vga_stream_checker;

  localparam int CH = 3;
  localparam int PW = 8;
  localparam int CW = 10;
  localparam int EW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic [1:0]    mode;
  logic          frame_start;
  logic          pix_valid;
  logic [CW-1:0] pix_x, pix_y;
  logic [23:0]   pix_data;
  logic          ref_valid;
  logic [23:0]   ref_data;
  logic          ref_ready;
  logic [EW-1:0] mismatch_count;
  logic          first_err;
  logic [CW-1:0] first_err_x, first_err_y;
  logic [1:0]    first_err_chan;
  logic [PW-1:0] first_err_exp, first_err_got;
  logic          underflow, aborted, frame_done;
  logic [1:0]    state_dbg;

  int n_total = 0;
  int n_bad   = 0;
  int hs      = 0;
  int hs0;
  logic [7:0] exp_q[$];
  logic [7:0] rv[4];
  logic [7:0] e;
  logic [23:0] d;

  vga_stream_checker #(
    .CHANNELS(CH), .PIX_W(PW), .COORD_W(CW),
    .VIEW_LEFT(1), .VIEW_RIGHT(5), .VIEW_TOP(1), .VIEW_BOTTOM(3), .ERR_W(EW)
  ) dut (
    .Clock_50(clk), .Reset(rst), .Enable(enable), .Mode(mode), .Frame_start(frame_start),
    .Pix_valid(pix_valid), .Pix_X(pix_x), .Pix_Y(pix_y), .Pix_data(pix_data),
    .Ref_valid(ref_valid), .Ref_data(ref_data), .Ref_ready(ref_ready),
    .Mismatch_count(mismatch_count), .First_err(first_err),
    .First_err_X(first_err_x), .First_err_Y(first_err_y), .First_err_chan(first_err_chan),
    .First_err_exp(first_err_exp), .First_err_got(first_err_got),
    .Underflow(underflow), .Aborted(aborted), .Frame_done(frame_done), .State_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst && ref_valid && ref_ready) hs <= hs + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_ref(input logic [23:0] r);
    ref_valid = 1'b1;
    ref_data  = r;
    tick();
    ref_valid = 1'b0;
  endtask

  task automatic pix(input int x, input int y, input logic [23:0] px);
    pix_valid = 1'b1;
    pix_x     = CW'(x);
    pix_y     = CW'(y);
    pix_data  = px;
    tick();
    pix_valid = 1'b0;
  endtask

  task automatic ref_pix(input int x, input int y, input logic [23:0] r, input logic [23:0] px);
    push_ref(r);
    pix(x, y, px);
  endtask

  task automatic fstart;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; mode = 2'd0; frame_start = 1'b0;
    pix_valid = 1'b0; pix_x = '0; pix_y = '0; pix_data = '0;
    ref_valid = 1'b0; ref_data = '0;
    tick(); tick();
    check("rst_state", 32'(state_dbg), 32'd0);
    check("rst_count", 32'(mismatch_count), 32'd0);
    check("rst_ready", 32'(ref_ready), 32'd0);
    check("rst_done", 32'(frame_done), 32'd0);
    @(negedge clk); rst = 1'b0;
    tick();
    enable = 1'b1;
    tick();
    check("wait_state", 32'(state_dbg), 32'd1);
    check("wait_ready", 32'(ref_ready), 32'd1);
    fstart();
    check("check_state", 32'(state_dbg), 32'd2);

    // 1: direct mode, single channel-1 error at (2,1)
    pix(0, 1, 24'hFFFFFF);
    check("t1_outview", 32'(mismatch_count), 32'd0);
    for (int y = 1; y <= 2; y++) begin
      for (int x = 1; x <= 4; x++) begin
        d = {8'(8'h30 + x), 8'h40, 8'(8'h10 + y)};
        if (x == 2 && y == 1) begin
          ref_pix(x, y, d, {d[23:16], 8'h41, d[7:0]});
          check("t1_latency", 32'(mismatch_count), 32'd1);
        end else begin
          if (x == 4 && y == 2) check("t1_not_done", 32'(frame_done), 32'd0);
          ref_pix(x, y, d, d);
        end
      end
    end
    check("t1_count", 32'(mismatch_count), 32'd1);
    check("t1_ferr", 32'(first_err), 32'd1);
    check("t1_fx", 32'(first_err_x), 32'd2);
    check("t1_fy", 32'(first_err_y), 32'd1);
    check("t1_fchan", 32'(first_err_chan), 32'd1);
    check("t1_fexp", 32'(first_err_exp), 32'h40);
    check("t1_fgot", 32'(first_err_got), 32'h41);
    check("t1_done", 32'(frame_done), 32'd1);
    check("t1_underflow", 32'(underflow), 32'd0);

    // 2: average mode
    mode = 2'd1;
    fstart();
    check("t2_clr_count", 32'(mismatch_count), 32'd0);
    check("t2_clr_ferr", 32'(first_err), 32'd0);
    rv = '{8'h10, 8'h20, 8'hFF, 8'hFF};
    exp_q = {8'h10, 8'h18, 8'h8F, 8'hFF};
    for (int i = 0; i < 4; i++) begin
      e = exp_q[i];
      ref_pix(i + 1, 1, {3{rv[i]}}, {3{e}});
    end
    check("t2_row1_count", 32'(mismatch_count), 32'd0);
    for (int i = 0; i < 4; i++) begin
      e = exp_q.pop_front();
      d = {3{e}};
      if (i == 2) d[7:0] = 8'h8E;
      ref_pix(i + 1, 2, {3{rv[i]}}, d);
    end
    check("t2_count", 32'(mismatch_count), 32'd1);
    check("t2_fx", 32'(first_err_x), 32'd3);
    check("t2_fy", 32'(first_err_y), 32'd2);
    check("t2_fchan", 32'(first_err_chan), 32'd0);
    check("t2_fexp", 32'(first_err_exp), 32'h8F);
    check("t2_fgot", 32'(first_err_got), 32'h8E);
    check("t2_done", 32'(frame_done), 32'd1);

    // 3: replicate mode
    mode = 2'd2;
    fstart();
    hs0 = hs;
    push_ref(24'h123456);
    pix(1, 1, 24'h123456);
    pix(2, 1, 24'h123456);
    push_ref(24'hABCDEF);
    pix(3, 1, 24'hABCDEF);
    pix(4, 1, 24'hABCDEF);
    check("t3_handshakes", 32'(hs - hs0), 32'd2);
    check("t3_count", 32'(mismatch_count), 32'd0);
    check("t3_underflow", 32'(underflow), 32'd0);

    // 4: underflow
    mode = 2'd0;
    hs0 = hs;
    pix(1, 2, 24'h000000);
    check("t4_underflow", 32'(underflow), 32'd1);
    check("t4_count", 32'(mismatch_count), 32'd0);
    check("t4_handshakes", 32'(hs - hs0), 32'd0);
    check("t4_ferr", 32'(first_err), 32'd0);

    // 5: abort, then saturation on a 4-bit counter
    fstart();
    check("t5_aborted", 32'(aborted), 32'd1);
    check("t5_abort_done", 32'(frame_done), 32'd1);
    check("t5_uf_hold", 32'(underflow), 32'd1);
    fstart();
    check("t5_clr_aborted", 32'(aborted), 32'd0);
    check("t5_clr_uf", 32'(underflow), 32'd0);
    for (int x = 1; x <= 4; x++) ref_pix(x, 1, 24'h0, 24'hFFFFFF);
    check("t5_count12", 32'(mismatch_count), 32'd12);
    ref_pix(1, 2, 24'h0, 24'hFFFFFF);
    ref_pix(2, 2, 24'h0, 24'hFFFFFF);
    ref_pix(3, 2, 24'h0, 24'h00FFFF);
    check("t5_saturated", 32'(mismatch_count), 32'hF);
    check("t5_fx", 32'(first_err_x), 32'd1);
    check("t5_fchan", 32'(first_err_chan), 32'd0);
    check("t5_fgot", 32'(first_err_got), 32'hFF);
    fstart();
    check("t5_aborted2", 32'(aborted), 32'd1);

    // 6: asynchronous reset mid-CHECK
    fstart();
    ref_pix(1, 1, 24'h0, 24'hFFFFFF);
    check("t6_count3", 32'(mismatch_count), 32'd3);
    push_ref(24'h000005);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_count", 32'(mismatch_count), 32'd0);
    check("t6_rst_ferr", 32'(first_err), 32'd0);
    check("t6_rst_fx", 32'(first_err_x), 32'd0);
    check("t6_rst_state", 32'(state_dbg), 32'd0);
    check("t6_rst_ready", 32'(ref_ready), 32'd0);
    @(negedge clk); rst = 1'b0;
    tick();
    check("t6_wait", 32'(state_dbg), 32'd1);
    check("t6_buf_cleared", 32'(ref_ready), 32'd1);
    fstart();
    ref_pix(1, 1, 24'h0A0B0C, 24'h0A0B0C);
    check("t6_clean_count", 32'(mismatch_count), 32'd0);
    check("t6_clean_ferr", 32'(first_err), 32'd0);
    ref_pix(2, 1, 24'h0, 24'h000100);
    check("t6_chan1", 32'(first_err_chan), 32'd1);

    // disable: IDLE next cycle, results hold
    enable = 1'b0;
    tick();
    check("dis_state", 32'(state_dbg), 32'd0);
    check("dis_ready", 32'(ref_ready), 32'd0);
    check("dis_hold", 32'(mismatch_count), 32'd1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
